// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, operand-B selects,
// writeback sources, multiply FSM states and small arithmetic helpers.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    aluop_add   = 4'd0,
    aluop_sub   = 4'd1,
    aluop_and   = 4'd2,
    aluop_or    = 4'd3,
    aluop_xor   = 4'd4,
    aluop_nor   = 4'd5,
    aluop_slt   = 4'd6,
    aluop_sltu  = 4'd7,
    aluop_sll   = 4'd8,
    aluop_srl   = 4'd9,
    aluop_sra   = 4'd10,
    aluop_lui   = 4'd11,
    aluop_mult  = 4'd12,
    aluop_multu = 4'd13,
    aluop_mfhi  = 4'd14,
    aluop_mflo  = 4'd15
  } aluop_e;

  typedef enum logic [1:0] {
    alu_src_rt     = 2'd0,
    alu_src_imm    = 2'd1,
    alu_src_link   = 2'd2,
    alu_src_rt_alt = 2'd3
  } alu_src_e;

  typedef enum logic [1:0] {
    wb_src_alu_result = 2'd0,
    wb_src_mem_data   = 2'd1,
    wb_src_pc         = 2'd2,
    wb_src_rsvd       = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    st_idle     = 2'd0,
    st_mul_busy = 2'd1,
    st_mul_done = 2'd2
  } mul_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  function automatic logic [63:0] apply_sign(input logic [63:0] p, input logic neg);
    return neg ? (64'd0 - p) : p;
  endfunction

endpackage

// File: rtl/ex_stage_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// MUL_ITERS cycles after start; done marks the cycle of the final iteration.
module mul_seq
  import ex_stage_pkg::*;
#(
  parameter int MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam int CW = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

  logic [63:0]   mcand;
  logic [31:0]   mplier;
  logic [63:0]   acc;
  logic [CW-1:0] count;
  logic          running;

  // Load operands on start, then add one shifted multiplicand per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand   <= 64'd0;
      mplier  <= 32'd0;
      acc     <= 64'd0;
      count   <= '0;
      running <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      mcand   <= {32'd0, a};
      mplier  <= b;
      acc     <= 64'd0;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= {mcand[62:0], 1'b0};
      mplier <= {1'b0, mplier[31:1]};
      count  <= count + CW'(1);
      if (count == LAST) running <= 1'b0;
    end
  end

  assign busy    = running;
  assign done    = running && (count == LAST);
  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM register and a stalling iterative HI/LO multiplier.
// Build option: ALU_OVF_EN blocks writeback and flags ovf_exc on signed add/sub overflow.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] ex_rdata1,
  input  logic [31:0] ex_rdata2,
  input  logic [31:0] ex_ext_imm,
  input  logic [4:0]  ex_sa,
  input  logic [3:0]  ex_aluop,
  input  logic [1:0]  ex_alu_src,
  input  logic        ex_mem_wr,
  input  logic        ex_reg_wr,
  input  logic [4:0]  ex_waddr,
  input  logic [1:0]  ex_reg_wb_src,
  input  logic [31:0] ex_pc,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_waddr,
  output logic        mem_reg_wr,
  output logic        mem_mem_wr,
  output logic [1:0]  mem_reg_wb_src,
  output logic [31:0] mem_pc,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        ovf_exc
);

`ifdef ALU_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  aluop_e      op;
  alu_src_e    src;
  mul_state_e  state;
  logic [31:0] opb, alu_res, mul_a, mul_b;
  logic [63:0] product;
  logic        ovf, ovf_kill, is_mul, is_signed_mul, start, bubble, mul_sign;
  logic        mul_busy, mul_done;

  assign op            = aluop_e'(ex_aluop);
  assign src           = alu_src_e'(ex_alu_src);
  assign is_signed_mul = (op == aluop_mult);
  assign is_mul        = is_signed_mul || (op == aluop_multu);
  assign mul_a         = is_signed_mul ? abs32(ex_rdata1) : ex_rdata1;
  assign mul_b         = is_signed_mul ? abs32(ex_rdata2) : ex_rdata2;
  assign start         = (state == st_idle) && is_mul && !flush && !mul_busy;
  assign bubble        = flush || stall_req || is_mul;
  assign ovf_kill      = ovf && OVF_EN;

  // Single-cycle ALU; a link select overrides the opcode with pc+8.
  always_comb begin
    opb     = (src == alu_src_imm) ? ex_ext_imm : ex_rdata2;
    alu_res = 32'h0;
    ovf     = 1'b0;
    if (src == alu_src_link) begin
      alu_res = ex_pc + 32'd8;
    end else begin
      case (op)
        aluop_add:  begin alu_res = ex_rdata1 + opb; ovf = add_ovf(ex_rdata1, opb); end
        aluop_sub:  begin alu_res = ex_rdata1 - opb; ovf = sub_ovf(ex_rdata1, opb); end
        aluop_and:  alu_res = ex_rdata1 & opb;
        aluop_or:   alu_res = ex_rdata1 | opb;
        aluop_xor:  alu_res = ex_rdata1 ^ opb;
        aluop_nor:  alu_res = ~(ex_rdata1 | opb);
        aluop_slt:  alu_res = {31'd0, $signed(ex_rdata1) < $signed(opb)};
        aluop_sltu: alu_res = {31'd0, ex_rdata1 < opb};
        aluop_sll:  alu_res = opb << ex_sa;
        aluop_srl:  alu_res = opb >> ex_sa;
        aluop_sra:  alu_res = $signed(opb) >>> ex_sa;
        aluop_lui:  alu_res = {opb[15:0], 16'h0000};
        aluop_mfhi: alu_res = hi_o;
        aluop_mflo: alu_res = lo_o;
        default:    alu_res = 32'h0;
      endcase
    end
  end

  // Stall covers the detect cycle and every busy cycle, but not the done cycle.
  always_comb begin
    stall_req = 1'b0;
    case (state)
      st_idle:     stall_req = is_mul && !flush;
      st_mul_busy: stall_req = 1'b1;
      st_mul_done: stall_req = 1'b0;
      default:     stall_req = 1'b0;
    endcase
  end

  mul_seq #(.MUL_ITERS(MUL_ITERS)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .abort   (flush),
    .start   (start),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // Multiply sequencing and HI/LO ownership; flush wins over completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= st_idle;
      mul_sign <= 1'b0;
      hi_o     <= 32'd0;
      lo_o     <= 32'd0;
    end else if (flush) begin
      state <= st_idle;
    end else begin
      case (state)
        st_idle: begin
          if (start) begin
            state    <= st_mul_busy;
            mul_sign <= is_signed_mul && (ex_rdata1[31] ^ ex_rdata2[31]);
          end
        end
        st_mul_busy: begin
          if (mul_done) state <= st_mul_done;
        end
        st_mul_done: begin
          {hi_o, lo_o} <= apply_sign(product, mul_sign);
          state        <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

  // EX/MEM register; stalls, multiplies and flushes insert a bubble.
  always_ff @(posedge clk) begin
    if (!rst || bubble) begin
      mem_alu_result <= 32'd0;
      mem_wdata      <= 32'd0;
      mem_waddr      <= 5'd0;
      mem_reg_wr     <= 1'b0;
      mem_mem_wr     <= 1'b0;
      mem_reg_wb_src <= wb_src_alu_result;
      mem_pc         <= 32'd0;
      ovf_exc        <= 1'b0;
    end else begin
      mem_alu_result <= alu_res;
      mem_wdata      <= ex_rdata2;
      mem_waddr      <= ex_waddr;
      mem_reg_wr     <= ex_reg_wr && !ovf_kill;
      mem_mem_wr     <= ex_mem_wr;
      mem_reg_wb_src <= ex_reg_wb_src;
      mem_pc         <= ex_pc;
      ovf_exc        <= ovf_kill;
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register. It sits directly downstream of the ID/EX register and consumes its ex_* outputs.
- A single-cycle ALU handles logic, arithmetic, shift, compare and link operations.
- An iterative 32-cycle multiplier handles MULT/MULTU, writes the HI/LO registers, and raises stall_req to freeze IF, ID and ID/EX while it runs.
- All results are registered into mem_* outputs for the MEM stage.

Parameters:
- MUL_ITERS, 32, number of shift-add iterations. Must equal the data width; any other value is unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  synchronous kill of the instruction in EX.
- ex_rdata1  in  32  rs operand.
- ex_rdata2  in  32  rt operand; also the store data.
- ex_ext_imm  in  32  extended immediate.
- ex_sa  in  5  shift amount.
- ex_aluop  in  4  operation code.
- ex_alu_src  in  2  operand-B select.
- ex_mem_wr  in  1  store enable.
- ex_reg_wr  in  1  GPR write enable.
- ex_waddr  in  5  GPR destination.
- ex_reg_wb_src  in  2  writeback source, passed through.
- ex_pc  in  32  instruction PC.
- mem_alu_result  out  32  registered result.
- mem_wdata  out  32  registered store data (ex_rdata2).
- mem_waddr  out  5  registered destination.
- mem_reg_wr  out  1  registered GPR write enable.
- mem_mem_wr  out  1  registered store enable.
- mem_reg_wb_src  out  2  registered writeback source.
- mem_pc  out  32  registered PC.
- stall_req  out  1  combinational; freezes the upstream stages.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.
- ovf_exc  out  1  registered overflow flag (see Optional Feature).

Behaviour:
- Reset (rst==0 at a clk edge):
  - All mem_* outputs go to 0, except mem_reg_wb_src = wb_src_alu_result.
  - hi_o = lo_o = 0, ovf_exc = 0, FSM = IDLE.
  - An in-flight multiply is discarded.
- Operand B by ex_alu_src:
  - alu_src_rt (00): ex_rdata2.
  - alu_src_imm (01): ex_ext_imm.
  - alu_src_link (10): the result is ex_pc+8 regardless of aluop.
  - 11: treated as rt.
- aluop encoding (0..15): add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, lui, mult, multu, mfhi, mflo.
- ALU operation rules:
  - add/sub: modulo 2^32.
  - slt: signed compare, result 1/0. sltu: unsigned compare.
  - sll/srl/sra: shift B by ex_sa.
  - lui: result = {B[15:0], 16'h0}.
  - mfhi/mflo: return the current hi_o/lo_o.
- Latency: one cycle. The EX inputs present at edge N appear on mem_* after edge N.
- FSM states: IDLE, MUL_BUSY, MUL_DONE.
- IDLE:
  - If aluop is mult/multu and flush==0: stall_req=1, capture |rs| and |rt| (mult) or the raw operands (multu), record the result sign, counter=0, go to MUL_BUSY.
  - Otherwise stall_req=0.
- MUL_BUSY:
  - stall_req=1; one shift-add iteration per cycle; counter increments.
  - After iteration MUL_ITERS-1, go to MUL_DONE.
- MUL_DONE:
  - stall_req=0.
  - {hi_o, lo_o} ← the 64-bit product, negated if the result sign is set.
  - Go to IDLE.
  - The mult advances out of EX on this edge.
- Multiply cost: mult/multu holds stall_req high for 33 consecutive cycles (the IDLE detect cycle plus 32 BUSY cycles).
- Register outputs for multiply: whenever stall_req==1, and for the mult itself, EX/MEM captures a bubble (mem_reg_wr=0, mem_mem_wr=0).
- mfhi/mflo immediately after a mult sees the updated HI/LO, because the pipeline was frozen until MUL_DONE.
- flush==1 at an edge:
  - EX/MEM captures a bubble and the FSM returns to IDLE.
  - An in-progress multiply is aborted and HI/LO are unchanged.
  - flush has priority over MUL_DONE.
- Reset mid-multiply has the same effect as flush, and additionally clears HI/LO.
- Interlock: upstream must hold the ID/EX contents stable while stall_req==1.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined:
  - Signed overflow on add or sub forces mem_reg_wr=0 for that instruction.
  - ovf_exc is asserted for exactly the one cycle in which that instruction occupies EX/MEM.
  - mem_alu_result still holds the wrapped sum.
- Undefined: add/sub wrap silently and ovf_exc is tied to 0.

Decomposition:
- definations.vh holds the shared constants:
  - aluop codes (aluop_add … aluop_mflo).
  - alu_src codes, including alu_src_link.
  - wb_src codes.
  - FSM state encodings.
- Natural sub-module: mul_seq, the iterative unsigned shift-add multiplier.
  - Ports: start, a, b, busy, done, product[63:0].
  - ex_stage owns sign handling and HI/LO.

Test Plan:
1. add 0x7FFFFFFF + 1 with alu_src_rt → mem_alu_result=0x80000000, mem_reg_wr follows ex_reg_wr. With ALU_OVF_EN: mem_reg_wr=0 and ovf_exc=1 for one cycle.
2. sra, B=0x80000010, sa=4 → mem_alu_result=0xF8000001. slt -1 vs 1 → 1. sltu -1 vs 1 → 0.
3. mult -3 × 7 → stall_req high 33 cycles with bubbles on mem_*. Then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. A following mflo returns 0xFFFFFFEB.
4. multu 0xFFFFFFFF × 0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001.
5. flush asserted during cycle 10 of a mult → stall_req drops next cycle, HI/LO keep prior values, mem_reg_wr=0.
6. rst=0 mid-mult and alu_src_link at pc=0x100 → reset gives all outputs 0 and HI/LO=0; link then gives mem_alu_result=0x108.
